// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder slice.
package dmem_pkg;

  localparam int WORD_W              = 32;
  localparam int DEFAULT_DEPTH       = 256;
  localparam int DEFAULT_WAIT_CYCLES = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with a registered read port and no reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              writeEn,
  input  logic              readEn,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Read data only updates on a read, so the last load result is held.
  always_ff @(posedge clk) begin
    if (writeEn) begin
      mem[addr] <= wdata;
    end
    if (readEn) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the pipeline MEM stage: IDLE/WAIT/RESP FSM.
// Optional address fault checking is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              stall
);

  localparam int AW = $clog2(DEPTH);

  state_t            state;
  state_t            nextState;
  logic [3:0]        waitCount;
  logic              capWrite;
  logic [31:0]       capAddr;
  logic [WORD_W-1:0] capWdata;
  logic              curWrite;
  logic [31:0]       curAddr;
  logic [WORD_W-1:0] curWdata;
  logic              accept;
  logic              enterResp;
  logic              fault;
  logic              rdataSel;
  logic [WORD_W-1:0] arrayRdata;

  // With zero wait states the commit edge is the accept edge, so the
  // live request is used in IDLE and the captured copy afterwards.
  assign curWrite  = (state == IDLE) ? req_write : capWrite;
  assign curAddr   = (state == IDLE) ? req_addr  : capAddr;
  assign curWdata  = (state == IDLE) ? req_wdata : capWdata;

  assign accept    = (state == IDLE) && req_valid && !rst;
  assign enterResp = !rst && ((accept && (WAIT_CYCLES == 0)) ||
                              ((state == WAIT) && (waitCount == 4'd1)));

  assign stall      = ((state == IDLE) && req_valid) || (state == WAIT);
  assign resp_rdata = rdataSel ? arrayRdata : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          nextState = (WAIT_CYCLES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (waitCount == 4'd1) begin
          nextState = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        nextState  = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      waitCount <= '0;
      capWrite  <= 1'b0;
      capAddr   <= '0;
      capWdata  <= '0;
      rdataSel  <= 1'b0;
    end else begin
      if (accept) begin
        waitCount <= 4'(WAIT_CYCLES);
        capWrite  <= req_write;
        capAddr   <= req_addr;
        capWdata  <= req_wdata;
      end else if (state == WAIT) begin
        waitCount <= waitCount - 4'd1;
      end
      if (enterResp) begin
        rdataSel <= !curWrite && !fault;
      end
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  logic errReg;

  assign fault    = (curAddr[1:0] != 2'b00) || (curAddr >= 32'(DEPTH * 4));
  assign resp_err = errReg;

  always_ff @(posedge clk) begin
    if (rst) begin
      errReg <= 1'b0;
    end else if (enterResp) begin
      errReg <= fault;
    end
  end
`else
  logic unusedAddrBits;

  // Byte offset and out-of-range bits are discarded, so the index wraps.
  assign fault          = 1'b0;
  assign resp_err       = 1'b0;
  assign unusedAddrBits = ^{curAddr[31:AW+2], curAddr[1:0]};
`endif

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .writeEn (enterResp && curWrite && !fault),
    .readEn  (enterResp && !curWrite && !fault),
    .addr    (curAddr[AW+1:2]),
    .wdata   (curWdata),
    .rdata   (arrayRdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed table-driven bench for dmem_responder (default WAIT_CYCLES and a zero-wait instance).
module tb_dmem_responder;

  localparam int WC = 2;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRdata;
    logic        expErr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_err, stall;
  logic [31:0] resp_rdata;

  logic        v0, w0;
  logic [31:0] a0, d0;
  logic        ready0, rv0, err0, stall0;
  logic [31:0] rdata0;

  int vecCount  = 0;
  int missCount = 0;
  vec_t vecs[12];
  int   nVecs;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(256), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .stall(stall)
  );

  dmem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(v0), .req_write(w0),
    .req_addr(a0), .req_wdata(d0), .req_ready(ready0),
    .resp_valid(rv0), .resp_rdata(rdata0), .resp_err(err0),
    .stall(stall0)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One full transaction on the main instance, checking timing and result.
  task automatic applyStimulus(input vec_t v);
    int lat;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = v.write;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    #1;
    checkOutput("readyIdle", 32'(req_ready), 32'd1);
    checkOutput("stallAccept", 32'(stall), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    #1;
    while (!resp_valid && lat < 20) begin
      checkOutput("stallWait", 32'(stall), 32'd1);
      checkOutput("readyWait", 32'(req_ready), 32'd0);
      @(negedge clk);
      #1;
      lat++;
    end
    checkOutput("latency", 32'(lat), 32'(WC + 1));
    if (resp_valid) begin
      checkOutput("rdata", resp_rdata, v.expRdata);
      checkOutput("err", 32'(resp_err), 32'(v.expErr));
      checkOutput("stallResp", 32'(stall), 32'd0);
      checkOutput("readyResp", 32'(req_ready), 32'd0);
      @(negedge clk);
      #1;
      checkOutput("respPulse", 32'(resp_valid), 32'd0);
      checkOutput("rdataHold", resp_rdata, v.expRdata);
    end
  endtask

  task automatic watchNoResp(input string name);
    int seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      if (resp_valid) seen++;
    end
    checkOutput(name, 32'(seen), 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1] = '{1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2] = '{1'b1, 32'h20, 32'h11112222, 32'h0,        1'b0};
    vecs[3] = '{1'b1, 32'h14, 32'hA5A5A5A5, 32'h0,        1'b0};
    vecs[4] = '{1'b0, 32'h14, 32'h0,        32'hA5A5A5A5, 1'b0};
    vecs[5] = '{1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[6] = '{1'b0, 32'h20, 32'h0,        32'h11112222, 1'b0};
`ifdef DMEM_ALIGN_CHECK_EN
    vecs[7] = '{1'b1, 32'h13,  32'h77777777, 32'h0,        1'b1};
    vecs[8] = '{1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
    vecs[9] = '{1'b0, 32'h400, 32'h0,        32'h0,        1'b1};
    vecs[10] = '{1'b1, 32'h3FC, 32'h0BADF00D, 32'h0,       1'b0};
    vecs[11] = '{1'b0, 32'h3FC, 32'h0,       32'h0BADF00D, 1'b0};
`else
    vecs[7] = '{1'b1, 32'h400, 32'h00001234, 32'h0,        1'b0};
    vecs[8] = '{1'b0, 32'h0,   32'h0,        32'h00001234, 1'b0};
    vecs[9] = '{1'b0, 32'h403, 32'h0,        32'h00001234, 1'b0};
    vecs[10] = '{1'b1, 32'h13, 32'h77777777, 32'h0,        1'b0};
    vecs[11] = '{1'b0, 32'h10, 32'h0,        32'h77777777, 1'b0};
`endif
    nVecs = 12;

    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    v0 = 1'b0; w0 = 1'b0; a0 = '0; d0 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rstReady", 32'(req_ready), 32'd1);
    checkOutput("rstRespValid", 32'(resp_valid), 32'd0);
    checkOutput("rstRdata", resp_rdata, 32'd0);
    checkOutput("rstErr", 32'(resp_err), 32'd0);
    checkOutput("rstStall", 32'(stall), 32'd0);

    for (int i = 0; i < nVecs; i++) begin
      applyStimulus(vecs[i]);
    end

    // Reset one cycle after accepting a store aborts it.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h55;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("abortReady", 32'(req_ready), 32'd1);
    checkOutput("abortRdata", resp_rdata, 32'd0);
    watchNoResp("abortNoResp");

    // Reset together with a request in IDLE: nothing is accepted.
    @(negedge clk);
    rst = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h99;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b0;
    #1;
    checkOutput("rstReqReady", 32'(req_ready), 32'd1);
    watchNoResp("rstReqNoResp");
    applyStimulus('{1'b0, 32'h20, 32'h0, 32'h11112222, 1'b0});

    // Zero-wait instance with request held continuously: accept/resp alternate.
    @(negedge clk);
    v0 = 1'b1; w0 = 1'b1; a0 = 32'h0; d0 = 32'hCAFE0000;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (k % 2 == 0) begin
        checkOutput("z.ready", 32'(ready0), 32'd1);
        checkOutput("z.stall", 32'(stall0), 32'd1);
        checkOutput("z.noResp", 32'(rv0), 32'd0);
      end else begin
        checkOutput("z.resp", 32'(rv0), 32'd1);
        checkOutput("z.stallResp", 32'(stall0), 32'd0);
        checkOutput("z.readyResp", 32'(ready0), 32'd0);
        checkOutput("z.rdata", rdata0, (k == 1) ? 32'h0 : 32'hCAFE0000);
        checkOutput("z.err", 32'(err0), 32'd0);
        w0 = 1'b0;
      end
      @(negedge clk);
    end
    v0 = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH, default 256, number of 32-bit words in storage (power of two).
REQ-002 Parameter WAIT_CYCLES, default 2, wait states between request accept and response (0..15).
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 req_valid  input  1  pipeline MEM stage presents a load/store request.
REQ-006 req_write  input  1  1 = store, 0 = load; qualified by req_valid.
REQ-007 req_addr  input  32  byte address.
REQ-008 req_wdata  input  32  store data.
REQ-009 req_ready  output  1  responder can accept a request this cycle.
REQ-010 resp_valid  output  1  one-cycle pulse; the transaction completes this cycle.
REQ-011 resp_rdata  output  32  load data; valid only with resp_valid.
REQ-012 resp_err  output  1  address fault; valid only with resp_valid.
REQ-013 stall  output  1  freezes the pipeline (PC, IF/ID, ID/EX, EX/MEM) while a request is outstanding.

Function
REQ-014 FSM states: IDLE, WAIT, RESP.
REQ-015 IDLE: req_ready = 1; on req_valid, capture req_write, req_addr and req_wdata.
REQ-016 On capture in IDLE: load the wait counter with WAIT_CYCLES and go to WAIT; if WAIT_CYCLES = 0, go directly to RESP.
REQ-017 WAIT: req_ready = 0; decrement the counter each cycle; on the edge where the counter equals 1, go to RESP.
REQ-018 The edge entering RESP commits a store to the array and registers load data into resp_rdata.
REQ-019 RESP: resp_valid = 1 for exactly one cycle, req_ready = 0; next state is IDLE unconditionally.
REQ-020 Latency: a request accepted at edge T gives resp_valid in cycle T+WAIT_CYCLES+1; no back-to-back accept, so the minimum spacing between accepts is WAIT_CYCLES+2 cycles.
REQ-021 stall = (req_valid and state = IDLE) or state = WAIT (combinational); stall is 0 in RESP so the pipeline advances on the completion cycle.
REQ-022 Word index = req_addr[log2(DEPTH)+1:2].
REQ-023 A load following a store to the same index returns the stored data.
REQ-024 req_valid deasserting during WAIT has no effect; the captured transaction completes.
REQ-025 resp_rdata holds its last value outside resp_valid; resp_rdata is 0 for store responses.

Reset
REQ-026 rst forces state = IDLE, counter = 0, resp_valid = 0, resp_rdata = 0, resp_err = 0 and captured-request registers = 0.
REQ-027 Array contents are not cleared by rst.
REQ-028 rst asserted in WAIT aborts the transaction: no store commit and no resp_valid.
REQ-029 rst in the same cycle as req_valid in IDLE: the request is not accepted.
REQ-030 After rst deasserts, req_ready = 1 in the first cycle.

Configuration
REQ-031 Macro DMEM_ALIGN_CHECK_EN defined: a request is faulted if req_addr[1:0] != 0 or req_addr >= DEPTH*4.
REQ-032 Response to a faulted request: resp_err = 1, resp_rdata = 0, store suppressed; timing is identical to a normal request.
REQ-033 Macro undefined: req_addr[1:0] is ignored, the index wraps modulo DEPTH, and resp_err is tied to 0.

Structure
REQ-034 Package dmem_pkg holds: the state enum (IDLE/WAIT/RESP), WORD_W = 32, and default values for DEPTH and WAIT_CYCLES.
REQ-035 One sub-module, dmem_array: single-port synchronous RAM with write enable, a registered read port and no reset.
REQ-036 dmem_responder contains the FSM, wait counter, capture registers and fault check.

Verification
REQ-037 Store 0xDEADBEEF to 0x10, then load 0x10 -> first resp_valid at cycle T+3; load returns 0xDEADBEEF; resp_err = 0.
REQ-038 WAIT_CYCLES = 0, load 0x0 held valid continuously -> resp_valid at T+1; next accept at T+2; stall is 1 only in the IDLE accept cycles.
REQ-039 rst pulsed one cycle after accepting store 0x55 to 0x20; then load 0x20 -> old value returned; no resp_valid for the aborted store.
REQ-040 With DMEM_ALIGN_CHECK_EN defined, store to 0x13 -> resp_err = 1, resp_rdata = 0; a later load of 0x10 returns the unchanged value.
REQ-041 Without the macro and DEPTH = 256, store 0x1234 to 0x400, then load 0x0 -> 0x1234 (index wrap); resp_err = 0.
REQ-042 req_valid dropped in cycle T+1 of a load -> resp_valid still at T+3 with correct data; stall = 1 during WAIT and 0 in RESP.
